scroll_field: RTL and testbench

Parametrised falling-object playfield: a COLS×ROWS visible bitmap with a SPAWN_ROWS-deep hidden buffer above it, advanced one row per `tick`. It accepts spawn patterns through a valid/ready handshake, detects collisions between the bottom row and the player mask, keeps a score, and provides a registered pixel read port for the VGA scan datapath. It sits between the spawner/random source and the colour lookup feeding `vga_adapter`.

---
 rtl/scroll_field_pkg.sv | 17 +
 rtl/field_read_port.sv | 49 ++++
 rtl/scroll_field.sv | 133 +++++++++++++
 tb/tb_scroll_field.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_field_pkg.sv
// Shared types and helpers for the scroll_field playfield family.
// Field storage is column-major; idx() maps (column, vertical index) to a flat bit.
package scroll_field_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_OVER = 1'b1
    } state_e;

    localparam logic SPAWN_CLEAR = 1'b0;

    function automatic int unsigned idx(input int unsigned col, input int unsigned i,
                                        input int unsigned h);
        return col * h + i;
    endfunction

endpackage

// File: rtl/field_read_port.sv
// Registered single-pixel read of a column-major field, with bounds check and
// player overlay on the bottom visible row.
module field_read_port
    import scroll_field_pkg::*;
#(
    parameter int unsigned COLS       = 16,
    parameter int unsigned ROWS       = 32,
    parameter int unsigned SPAWN_ROWS = 16
) (
    input  logic                                  i_clock,
    input  logic                                  i_resetn,
    input  logic [COLS*(SPAWN_ROWS+ROWS)-1:0]     i_field,
    input  logic [COLS-1:0]                       i_player_mask,
    input  logic [$clog2(COLS)-1:0]               i_rd_col,
    input  logic [$clog2(ROWS)-1:0]               i_rd_row,
    output logic                                  o_rd_pixel,
    output logic                                  o_rd_player
);

    localparam int unsigned H  = SPAWN_ROWS + ROWS;
    localparam int unsigned FW = COLS * H;
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned IW = $clog2(FW);

    logic [CW:0]   w_col_ext;
    logic [RW:0]   w_row_ext;
    logic          w_in_range;
    logic          w_bottom_row;
    logic [IW-1:0] w_idx;

    // One extra bit so non-power-of-two dimensions can be range-checked.
    assign w_col_ext    = {1'b0, i_rd_col};
    assign w_row_ext    = {1'b0, i_rd_row};
    assign w_in_range   = (w_col_ext < (CW+1)'(COLS)) && (w_row_ext < (RW+1)'(ROWS));
    assign w_bottom_row = (w_row_ext == (RW+1)'(ROWS - 1));
    assign w_idx        = IW'(idx(32'(i_rd_col), SPAWN_ROWS + 32'(i_rd_row), H));

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            o_rd_pixel  <= 1'b0;
            o_rd_player <= 1'b0;
        end else begin
            o_rd_pixel  <= w_in_range & i_field[w_idx];
            o_rd_player <= w_in_range & w_bottom_row & i_player_mask[i_rd_col];
        end
    end

endmodule

// File: rtl/scroll_field.sv
// Falling-object playfield: hidden spawn buffer above a visible bitmap, shifted
// down one row per tick, with player collision detection and a cleared-row score.
module scroll_field
    import scroll_field_pkg::*;
#(
    parameter int unsigned COLS       = 16,
    parameter int unsigned ROWS       = 32,
    parameter int unsigned SPAWN_ROWS = 16,
    parameter int unsigned SCORE_W    = 8
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic                         tick,
    input  logic                         restart,
    input  logic                         spawn_valid,
    output logic                         spawn_ready,
    input  logic [COLS*SPAWN_ROWS-1:0]   spawn_data,
    input  logic [COLS-1:0]              player_mask,
    input  logic [$clog2(COLS)-1:0]      rd_col,
    input  logic [$clog2(ROWS)-1:0]      rd_row,
    output logic                         rd_pixel,
    output logic                         rd_player,
    output logic                         hit,
    output logic                         game_over,
    output logic [SCORE_W-1:0]           score
);

    localparam int unsigned H     = SPAWN_ROWS + ROWS;
    localparam int unsigned FW    = COLS * H;
    localparam int unsigned CNT_W = $clog2(SPAWN_ROWS + 1);

    state_e             r_state, w_state_nxt;
    logic [FW-1:0]      r_field, w_field_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [SCORE_W-1:0] r_score, w_score_nxt;
    logic               r_hit, w_hit_nxt;
    logic               r_game_over;

    logic [COLS-1:0]    w_bottom;
    logic [FW-1:0]      w_shift;
    logic [FW-1:0]      w_base;
    logic [FW-1:0]      w_loaded;
    logic               w_run, w_tick, w_accept, w_collide, w_do_shift;

    // Per-column views: discarded bottom bit, shifted column, and buffer load.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        assign w_bottom[c] = r_field[idx(c, H - 1, H)];
        assign w_shift[idx(c, 0, H) +: H] = {r_field[idx(c, 0, H) +: H - 1], 1'b0};
        assign w_loaded[idx(c, 0, H) +: H] = {w_base[idx(c, SPAWN_ROWS, H) +: ROWS],
                                               spawn_data[c*SPAWN_ROWS +: SPAWN_ROWS]};
    end

    assign w_run       = enable & (r_state == ST_RUN);
    assign spawn_ready = w_run & (r_cnt == CNT_W'(SPAWN_ROWS));
    assign w_accept    = spawn_valid & spawn_ready;
    assign w_tick      = w_run & tick;
    assign w_collide   = |(w_bottom & player_mask);
    assign w_do_shift  = w_tick & ~w_collide;
    assign w_base      = w_do_shift ? w_shift : r_field;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_RUN;
            r_field     <= {FW{SPAWN_CLEAR}};
            r_cnt       <= CNT_W'(SPAWN_ROWS);
            r_score     <= '0;
            r_hit       <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_field     <= w_field_nxt;
            r_cnt       <= w_cnt_nxt;
            r_score     <= w_score_nxt;
            r_hit       <= w_hit_nxt;
            r_game_over <= (w_state_nxt == ST_OVER);
        end
    end

    // Next state: restart dominates; shift is applied before a same-cycle buffer load.
    always_comb begin
        w_state_nxt = r_state;
        w_field_nxt = r_field;
        w_cnt_nxt   = r_cnt;
        w_score_nxt = r_score;
        w_hit_nxt   = 1'b0;
        if (restart) begin
            w_state_nxt = ST_RUN;
            w_field_nxt = {FW{SPAWN_CLEAR}};
            w_cnt_nxt   = CNT_W'(SPAWN_ROWS);
            w_score_nxt = '0;
        end else begin
            if (w_tick) begin
                if (w_collide) begin
                    w_state_nxt = ST_OVER;
                    w_hit_nxt   = 1'b1;
                end else begin
                    w_field_nxt = w_shift;
                    if (r_cnt != CNT_W'(SPAWN_ROWS)) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                    if ((|w_bottom) && (r_score != {SCORE_W{1'b1}})) begin
                        w_score_nxt = r_score + SCORE_W'(1);
                    end
                end
            end
            if (w_accept) begin
                w_field_nxt = w_loaded;
                w_cnt_nxt   = '0;
            end
        end
    end

    field_read_port #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .SPAWN_ROWS (SPAWN_ROWS)
    ) u_read_port (
        .i_clock       (clock),
        .i_resetn      (resetn),
        .i_field       (r_field),
        .i_player_mask (player_mask),
        .i_rd_col      (rd_col),
        .i_rd_row      (rd_row),
        .o_rd_pixel    (rd_pixel),
        .o_rd_player   (rd_player)
    );

    assign hit       = r_hit;
    assign game_over = r_game_over;
    assign score     = r_score;

endmodule

// File: tb/tb_scroll_field.sv
// Self-checking bench for scroll_field: directed scenarios plus randomized traffic
// against a row/column array model; a second small instance covers saturation and bounds.
module tb_scroll_field;

    localparam int COLS = 16;
    localparam int ROWS = 32;
    localparam int SR   = 16;
    localparam int H    = SR + ROWS;
    localparam int SW   = 8;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              enable = 1'b0, tick = 1'b0, restart = 1'b0, spawn_valid = 1'b0;
    logic              spawn_ready;
    logic [COLS*SR-1:0] spawn_data = '0;
    logic [COLS-1:0]   player_mask = '0;
    logic [3:0]        rd_col = '0;
    logic [4:0]        rd_row = '0;
    logic              rd_pixel, rd_player, hit, game_over;
    logic [SW-1:0]     score;

    // Small instance: 12 x 20 visible, 4 buffer rows, 2-bit score.
    logic              s_enable = 1'b0, s_tick = 1'b0, s_restart = 1'b0, s_valid = 1'b0;
    logic              s_ready;
    logic [47:0]       s_data = '0;
    logic [11:0]       s_mask = '0;
    logic [3:0]        s_rd_col = '0;
    logic [4:0]        s_rd_row = '0;
    logic              s_pixel, s_player, s_hit, s_over;
    logic [1:0]        s_score;

    int checks = 0;
    int failures = 0;

    bit mf [COLS][H];
    int mcnt, mscore;
    bit mover, mhit, epix, eply;

    always #5 clock = ~clock;

    scroll_field #(.COLS(COLS), .ROWS(ROWS), .SPAWN_ROWS(SR), .SCORE_W(SW)) dut (
        .clock(clock), .resetn(resetn), .enable(enable), .tick(tick), .restart(restart),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_data(spawn_data),
        .player_mask(player_mask), .rd_col(rd_col), .rd_row(rd_row), .rd_pixel(rd_pixel),
        .rd_player(rd_player), .hit(hit), .game_over(game_over), .score(score)
    );

    scroll_field #(.COLS(12), .ROWS(20), .SPAWN_ROWS(4), .SCORE_W(2)) dut_s (
        .clock(clock), .resetn(resetn), .enable(s_enable), .tick(s_tick), .restart(s_restart),
        .spawn_valid(s_valid), .spawn_ready(s_ready), .spawn_data(s_data),
        .player_mask(s_mask), .rd_col(s_rd_col), .rd_row(s_rd_row), .rd_pixel(s_pixel),
        .rd_player(s_player), .hit(s_hit), .game_over(s_over), .score(s_score)
    );

    task automatic model_clear();
        foreach (mf[c, i]) mf[c][i] = 1'b0;
        mcnt = SR;
        mscore = 0;
        mover = 1'b0;
        mhit = 1'b0;
    endtask

    function automatic bit exp_ready();
        return enable && !mover && (mcnt == SR);
    endfunction

    // Advance one clock, updating the model from the inputs presented at the edge.
    task automatic step();
        bit run, acc, coll, nz;
        run = enable && !mover;
        acc = spawn_valid && run && (mcnt == SR);
        epix = mf[rd_col][SR + int'(rd_row)];
        eply = (rd_row == 5'(ROWS - 1)) && player_mask[rd_col];
        if (restart) begin
            model_clear();
        end else begin
            mhit = 1'b0;
            if (run && tick) begin
                coll = 1'b0;
                nz = 1'b0;
                for (int c = 0; c < COLS; c++) begin
                    coll |= mf[c][H-1] & player_mask[c];
                    nz |= mf[c][H-1];
                end
                if (coll) begin
                    mover = 1'b1;
                    mhit = 1'b1;
                end else begin
                    for (int c = 0; c < COLS; c++) begin
                        for (int i = H - 1; i > 0; i--) mf[c][i] = mf[c][i-1];
                        mf[c][0] = 1'b0;
                    end
                    if (mcnt < SR) mcnt++;
                    if (nz && mscore < 255) mscore++;
                end
            end
            if (acc) begin
                for (int c = 0; c < COLS; c++)
                    for (int r = 0; r < SR; r++) mf[c][r] = spawn_data[c*SR + r];
                mcnt = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1; step(); tick = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1; step(); restart = 1'b0;
    endtask

    task automatic accept(input int bitpos);
        spawn_data = '0;
        spawn_data[bitpos] = 1'b1;
        spawn_valid = 1'b1; step(); spawn_valid = 1'b0;
    endtask

    task automatic read_px(input int c, input int r);
        rd_col = 4'(c); rd_row = 5'(r); step();
    endtask

    task automatic test_reset();
        enable = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        model_clear();
        checks++; if (spawn_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", spawn_ready); end
        checks++; if (score !== 8'd0) begin failures++; $display("FAIL reset_score got %0d want 0", score); end
        checks++; if (hit !== 1'b0 || game_over !== 1'b0) begin failures++; $display("FAIL reset_flags got hit=%b over=%b want 0 0", hit, game_over); end
        checks++; if (rd_pixel !== 1'b0) begin failures++; $display("FAIL reset_pixel got %b want 0", rd_pixel); end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                read_px(c, r);
                checks++; if (rd_pixel !== 1'b0) begin failures++; $display("FAIL reset_scan (%0d,%0d) got %b want 0", c, r, rd_pixel); end
            end
        end
    endtask

    task automatic test_spawn_latency();
        pulse_restart();
        accept(3*SR + 15);
        checks++; if (spawn_ready !== 1'b0) begin failures++; $display("FAIL lat_ready_after_accept got %b want 0", spawn_ready); end
        pulse_tick();
        checks++; if (spawn_ready !== 1'b0) begin failures++; $display("FAIL lat_ready_t1 got %b want 0", spawn_ready); end
        read_px(3, 0);
        checks++; if (rd_pixel !== 1'b1) begin failures++; $display("FAIL lat_pixel_3_0 got %b want 1", rd_pixel); end
        read_px(3, 1);
        checks++; if (rd_pixel !== 1'b0) begin failures++; $display("FAIL lat_pixel_3_1 got %b want 0", rd_pixel); end
        for (int k = 2; k <= SR; k++) begin
            pulse_tick();
            checks++; if (spawn_ready !== (k == SR)) begin failures++; $display("FAIL lat_ready_t%0d got %b want %b", k, spawn_ready, k == SR); end
        end
    endtask

    task automatic test_clear_score();
        pulse_restart();
        accept(5*SR);
        player_mask = 16'h0001;
        for (int k = 1; k <= H - 1; k++) begin
            pulse_tick();
            checks++; if (hit !== 1'b0) begin failures++; $display("FAIL clear_hit t%0d got %b want 0", k, hit); end
        end
        read_px(5, ROWS - 1);
        checks++; if (rd_pixel !== 1'b1 || rd_player !== 1'b0) begin failures++; $display("FAIL clear_bottom got pix=%b ply=%b want 1 0", rd_pixel, rd_player); end
        read_px(0, ROWS - 1);
        checks++; if (rd_player !== 1'b1) begin failures++; $display("FAIL clear_player0 got %b want 1", rd_player); end
        pulse_tick();
        checks++; if (score !== 8'd1 || hit !== 1'b0 || game_over !== 1'b0) begin failures++; $display("FAIL clear_score got score=%0d hit=%b over=%b want 1 0 0", score, hit, game_over); end
        read_px(5, ROWS - 1);
        checks++; if (rd_pixel !== 1'b0) begin failures++; $display("FAIL clear_exit got %b want 0", rd_pixel); end
        player_mask = '0;
    endtask

    task automatic test_collision();
        pulse_restart();
        accept(5*SR);
        player_mask = 16'h0020;
        for (int k = 1; k <= H - 1; k++) begin
            pulse_tick();
            checks++; if (hit !== 1'b0) begin failures++; $display("FAIL coll_early_hit t%0d got %b want 0", k, hit); end
        end
        pulse_tick();
        checks++; if (hit !== 1'b1 || game_over !== 1'b1) begin failures++; $display("FAIL coll_hit got hit=%b over=%b want 1 1", hit, game_over); end
        step();
        checks++; if (hit !== 1'b0 || game_over !== 1'b1) begin failures++; $display("FAIL coll_pulse got hit=%b over=%b want 0 1", hit, game_over); end
        repeat (3) pulse_tick();
        read_px(5, ROWS - 1);
        checks++; if (rd_pixel !== 1'b1 || rd_player !== 1'b1) begin failures++; $display("FAIL coll_frozen got pix=%b ply=%b want 1 1", rd_pixel, rd_player); end
        checks++; if (score !== 8'd0 || spawn_ready !== 1'b0 || hit !== 1'b0) begin failures++; $display("FAIL coll_over got score=%0d ready=%b hit=%b want 0 0 0", score, spawn_ready, hit); end
    endtask

    task automatic test_restart();
        enable = 1'b0;
        pulse_restart();
        enable = 1'b1;
        #1;
        checks++; if (game_over !== 1'b0 || score !== 8'd0 || spawn_ready !== 1'b1) begin failures++; $display("FAIL restart got over=%b score=%0d ready=%b want 0 0 1", game_over, score, spawn_ready); end
        for (int r = 0; r < ROWS; r++) begin
            read_px(5, r);
            checks++; if (rd_pixel !== 1'b0) begin failures++; $display("FAIL restart_clear row%0d got %b want 0", r, rd_pixel); end
        end
        player_mask = '0;
    endtask

    task automatic test_back_to_back();
        pulse_restart();
        accept(0);
        repeat (SR) pulse_tick();
        checks++; if (spawn_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got %b want 1", spawn_ready); end
        spawn_data = '0;
        spawn_data[1*SR + 15] = 1'b1;
        tick = 1'b1; spawn_valid = 1'b1; step(); tick = 1'b0; spawn_valid = 1'b0;
        checks++; if (spawn_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_after got %b want 0", spawn_ready); end
        read_px(0, 1);
        checks++; if (rd_pixel !== 1'b1) begin failures++; $display("FAIL b2b_shifted got %b want 1", rd_pixel); end
        read_px(1, 0);
        checks++; if (rd_pixel !== 1'b0) begin failures++; $display("FAIL b2b_buffer_hidden got %b want 0", rd_pixel); end
        pulse_tick();
        read_px(1, 0);
        checks++; if (rd_pixel !== 1'b1) begin failures++; $display("FAIL b2b_new_row0 got %b want 1", rd_pixel); end
        read_px(0, 2);
        checks++; if (rd_pixel !== 1'b1) begin failures++; $display("FAIL b2b_old_row2 got %b want 1", rd_pixel); end
    endtask

    task automatic test_enable();
        pulse_restart();
        accept(2*SR + 15);
        pulse_tick();
        enable = 1'b0;
        spawn_data = '1;
        tick = 1'b1; spawn_valid = 1'b1;
        repeat (3) step();
        tick = 1'b0; spawn_valid = 1'b0;
        checks++; if (spawn_ready !== 1'b0) begin failures++; $display("FAIL en_ready_low got %b want 0", spawn_ready); end
        read_px(2, 0);
        checks++; if (rd_pixel !== 1'b1) begin failures++; $display("FAIL en_frozen_row0 got %b want 1", rd_pixel); end
        read_px(2, 1);
        checks++; if (rd_pixel !== 1'b0) begin failures++; $display("FAIL en_frozen_row1 got %b want 0", rd_pixel); end
        enable = 1'b1;
        #1;
        checks++; if (spawn_ready !== 1'b0) begin failures++; $display("FAIL en_ready_cnt got %b want 0", spawn_ready); end
        enable = 1'b0;
        pulse_restart();
        read_px(2, 0);
        checks++; if (rd_pixel !== 1'b0) begin failures++; $display("FAIL en_restart_clear got %b want 0", rd_pixel); end
        enable = 1'b1;
        #1;
        checks++; if (spawn_ready !== 1'b1) begin failures++; $display("FAIL en_restart_ready got %b want 1", spawn_ready); end
    endtask

    task automatic test_random();
        pulse_restart();
        for (int n = 0; n < 3000; n++) begin
            enable      = ($urandom_range(0, 15) != 0);
            tick        = ($urandom_range(0, 2) == 0);
            restart     = ($urandom_range(0, 59) == 0);
            spawn_valid = $urandom_range(0, 1) != 0;
            for (int w = 0; w < COLS*SR/32; w++) spawn_data[w*32 +: 32] = $urandom & $urandom & $urandom;
            player_mask = ($urandom_range(0, 3) == 0) ? (16'($urandom) & 16'($urandom) & 16'($urandom)) : '0;
            rd_col      = 4'($urandom);
            rd_row      = ($urandom_range(0, 3) == 0) ? 5'(ROWS - 1) : 5'($urandom);
            step();
            checks++; if (spawn_ready !== exp_ready()) begin failures++; $display("FAIL rnd_ready n%0d got %b want %b", n, spawn_ready, exp_ready()); end
            checks++; if (rd_pixel !== epix || rd_player !== eply) begin failures++; $display("FAIL rnd_read n%0d got %b%b want %b%b", n, rd_pixel, rd_player, epix, eply); end
            checks++; if (hit !== mhit || game_over !== mover) begin failures++; $display("FAIL rnd_flags n%0d got %b%b want %b%b", n, hit, game_over, mhit, mover); end
            checks++; if (score !== 8'(mscore)) begin failures++; $display("FAIL rnd_score n%0d got %0d want %0d", n, score, mscore); end
        end
        enable = 1'b1; tick = 1'b0; restart = 1'b0; spawn_valid = 1'b0; player_mask = '0;
    endtask

    task automatic test_async_reset();
        pulse_restart();
        accept(7*SR + 15);
        pulse_tick();
        read_px(7, 0);
        checks++; if (rd_pixel !== 1'b1) begin failures++; $display("FAIL arst_pre got %b want 1", rd_pixel); end
        #2;
        resetn = 1'b0;
        #1;
        model_clear();
        checks++; if (rd_pixel !== 1'b0 || score !== 8'd0 || game_over !== 1'b0 || spawn_ready !== 1'b1) begin failures++; $display("FAIL arst_now got pix=%b score=%0d over=%b ready=%b want 0 0 0 1", rd_pixel, score, game_over, spawn_ready); end
        resetn = 1'b1;
        read_px(7, 0);
        checks++; if (rd_pixel !== 1'b0) begin failures++; $display("FAIL arst_cleared got %b want 0", rd_pixel); end
    endtask

    task automatic test_small();
        s_enable = 1'b1;
        s_restart = 1'b1; step(); s_restart = 1'b0;
        s_data = 48'hF;
        s_valid = 1'b1; step(); s_valid = 1'b0;
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL sm_ready got %b want 0", s_ready); end
        for (int k = 1; k <= 24; k++) begin
            s_tick = 1'b1; step(); s_tick = 1'b0;
            if (k == 20) begin
                checks++; if (s_score !== 2'd0) begin failures++; $display("FAIL sm_score_t20 got %0d want 0", s_score); end
            end
            if (k == 21) begin
                checks++; if (s_score !== 2'd1) begin failures++; $display("FAIL sm_score_t21 got %0d want 1", s_score); end
            end
            if (k == 22) begin
                checks++; if (s_score !== 2'd2) begin failures++; $display("FAIL sm_score_t22 got %0d want 2", s_score); end
            end
        end
        checks++; if (s_score !== 2'd3 || s_hit !== 1'b0 || s_ready !== 1'b1) begin failures++; $display("FAIL sm_saturate got score=%0d hit=%b ready=%b want 3 0 1", s_score, s_hit, s_ready); end
        s_data = '1;
        s_valid = 1'b1; step(); s_valid = 1'b0;
        repeat (4) begin s_tick = 1'b1; step(); s_tick = 1'b0; end
        s_mask = 12'hFFF;
        s_rd_col = 4'd11; s_rd_row = 5'd0; step();
        checks++; if (s_pixel !== 1'b1) begin failures++; $display("FAIL sm_in_range got %b want 1", s_pixel); end
        s_rd_col = 4'd12; s_rd_row = 5'd0; step();
        checks++; if (s_pixel !== 1'b0) begin failures++; $display("FAIL sm_col12 got %b want 0", s_pixel); end
        s_rd_col = 4'd15; s_rd_row = 5'd3; step();
        checks++; if (s_pixel !== 1'b0) begin failures++; $display("FAIL sm_col15 got %b want 0", s_pixel); end
        s_rd_col = 4'd0; s_rd_row = 5'd20; step();
        checks++; if (s_pixel !== 1'b0 || s_player !== 1'b0) begin failures++; $display("FAIL sm_row20 got %b%b want 00", s_pixel, s_player); end
        s_rd_col = 4'd11; s_rd_row = 5'd19; step();
        checks++; if (s_pixel !== 1'b0 || s_player !== 1'b1) begin failures++; $display("FAIL sm_player11 got %b%b want 01", s_pixel, s_player); end
        s_rd_col = 4'd12; s_rd_row = 5'd19; step();
        checks++; if (s_player !== 1'b0) begin failures++; $display("FAIL sm_player12 got %b want 0", s_player); end
    endtask

    initial begin
        test_reset();
        test_spawn_latency();
        test_clear_score();
        test_collision();
        test_restart();
        test_back_to_back();
        test_enable();
        test_random();
        test_async_reset();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
